sar_scan_ctl: RTL and testbench
===============================

Name: sar_scan_ctl

Overview:
- Synthesizable SAR ADC sequencer for the analog comparator/mux macro.
- Scans a masked set of channels round-robin and drives channel select, S/H reset, S/H hold and the DAC code.
- Resolves each sample MSB-first from the comparator output and publishes one result per channel.
- Generalises the fixed 14-ch/10-bit arrangement: parametrised channel count, resolution and timing, guaranteed non-overlap, and a one-shot scan mode.

Parameters:
- N_CHNL, 14, number of analog channels.
- DAC_W, 10, DAC/result width in bits.
- T_RST, 2, cycles sh_rst is high per conversion (>=1).
- T_GAP, 1, dead cycles between sh_rst fall and dac_sel rise (>=1).
- T_SMP, 8, sampling cycles with dac_sel on and sh_hold low (>=1).
- T_BIT, 4, settle cycles per SAR bit (>=3, covers comp_i sync).

Ports:
- clk  in  1  system clock.
- rstz  in  1  async active-low reset.
- scan_en  in  1  level; 1 = scanning allowed.
- oneshot  in  1  1 = convert each masked channel once, then stop.
- chn_mask  in  N_CHNL  channel enable mask.
- comp_i  in  1  comparator output (1 = v_cap > v_dac); asynchronous.
- dac_sel  out  N_CHNL  one-hot channel select, or 0.
- sh_rst  out  1  S/H cap discharge.
- sh_hold  out  1  0 = track, 1 = hold.
- dac_code  out  DAC_W  SAR trial code.
- busy  out  1  FSM not in IDLE.
- res_vld  out  1  1-cycle result strobe.
- res_chn  out  $clog2(N_CHNL)  channel of result.
- res_dat  out  DAC_W  conversion result.
- scan_done  out  1  sticky; set at end of a one-shot pass.

Behaviour:
- Reset values (async, rstz low, including mid-conversion): dac_sel=0, sh_rst=0, sh_hold=1, dac_code=0, busy=0, res_vld=0, res_chn=0, res_dat=0, scan_done=0, FSM=IDLE, round-robin pointer=N_CHNL-1.
- All outputs are registered.
- comp_i passes through a 2-flop synchroniser; SAR decisions use only the synchronised value.
- FSM states: IDLE, PICK, RST, GAP, SMP, CONV, DONE.
- IDLE -> PICK when scan_en=1, |chn_mask, and scan_done=0.
- PICK (1 cycle): choose first set mask bit searching from pointer+1 upward with wrap; update pointer.
  - If the mask is now 0, return to IDLE.
- RST: sh_rst=1, sh_hold=1, dac_sel=0 for T_RST cycles.
- GAP: all of dac_sel/sh_rst low, sh_hold=1, for T_GAP cycles.
- SMP: dac_sel=one-hot(pointer), sh_hold=0 for T_SMP cycles.
  - On exit, dac_sel->0 and sh_hold->1 in the same cycle.
- Non-overlap rules:
  - dac_sel and sh_rst are never both nonzero in any cycle, nor on adjacent cycles.
  - sh_hold=0 never coincides with or is adjacent to sh_rst=1.
- CONV: sh_hold=1, DAC_W bit windows of T_BIT cycles each, bit i from DAC_W-1 down to 0.
  - Window start: dac_code = kept | (1<<i).
  - Last window cycle: if synchronised comp_i=1, keep bit i; otherwise clear it.
  - Outside CONV, dac_code=0.
- DONE (1 cycle): res_vld=1, res_dat=kept, res_chn=pointer.
  - res_dat and res_chn hold until the next res_vld.
- After DONE:
  - scan_en=0 -> IDLE. A scan_en drop mid-conversion still completes the current channel.
  - oneshot=1 and pointer was the highest set bit of chn_mask (pass complete) -> set scan_done, go to IDLE.
  - Otherwise -> PICK.
- scan_done clears when scan_en=0; one-shot restart needs a scan_en low-high toggle.
- chn_mask and oneshot are sampled only in PICK/DONE; changes mid-conversion take effect at the next PICK.
- Single-bit mask converts that channel repeatedly.
- Per-channel latency PICK-to-res_vld = 1+T_RST+T_GAP+T_SMP+DAC_W*T_BIT+1. Defaults: 53 cycles.
- busy=1 in every state except IDLE.

Test Plan:
- Reset then scan_en=1, oneshot=0, chn_mask=14'h0004, bench comparator v_in=700mV vs dac_code*2mV: res_vld every 53 cycles, res_chn=2, res_dat=349.
- chn_mask=14'h0023, v_in = 0/1000/2046mV on ch0/1/5: result order ch0, ch1, ch5, ch0, ...; res_dat = 0, 499, 1022.
- Overlap checker on every cycle through a 100-conversion random-mask run:
  - (|dac_sel)&sh_rst never true.
  - Registered-previous versions of the same terms never true.
  - ~sh_hold&sh_rst never true.
  - dac_sel always one-hot or zero.
- oneshot=1, chn_mask=14'h0300: exactly two res_vld (ch8, ch9), then scan_done=1, busy=0. No further activity until a scan_en 0->1 toggle, which restarts at ch8.
- Drop scan_en in CONV bit 5; separately assert rstz low in SMP:
  - scan_en case: conversion completes, one res_vld, then IDLE.
  - reset case: immediately dac_sel=0, sh_hold=1, dac_code=0, busy=0, no res_vld.
- chn_mask=0 with scan_en=1: busy stays 0, no outputs toggle. Set mask to 14'h2000 mid-idle: first res_chn=13. Then set mask to 14'h0001 during CONV: next res_chn=0 (pointer wraps).

Source files
------------

// File: rtl/sar_scan_ctl.sv
// SAR ADC scan sequencer: round-robin channel pick, S/H reset/sample, MSB-first SAR.
module sar_scan_ctl #(
  parameter int unsigned N_CHNL = 14,
  parameter int unsigned DAC_W  = 10,
  parameter int unsigned T_RST  = 2,
  parameter int unsigned T_GAP  = 1,
  parameter int unsigned T_SMP  = 8,
  parameter int unsigned T_BIT  = 4
) (
  input  logic                      clk,
  input  logic                      rstz,
  input  logic                      scan_en,
  input  logic                      oneshot,
  input  logic [N_CHNL-1:0]         chn_mask,
  input  logic                      comp_i,
  output logic [N_CHNL-1:0]         dac_sel,
  output logic                      sh_rst,
  output logic                      sh_hold,
  output logic [DAC_W-1:0]          dac_code,
  output logic                      busy,
  output logic                      res_vld,
  output logic [$clog2(N_CHNL)-1:0] res_chn,
  output logic [DAC_W-1:0]          res_dat,
  output logic                      scan_done
);

  localparam int unsigned CW     = $clog2(N_CHNL);
  localparam int unsigned BW     = (DAC_W > 1) ? $clog2(DAC_W) : 1;
  localparam int unsigned T_MAX1 = (T_RST > T_GAP) ? T_RST : T_GAP;
  localparam int unsigned T_MAX2 = (T_SMP > T_BIT) ? T_SMP : T_BIT;
  localparam int unsigned T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
  localparam int unsigned TW     = $clog2(T_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_RST, S_GAP, S_SMP, S_CONV, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [DAC_W-1:0]    kept_q, kept_d;
  logic                done_q, done_d;
  logic                comp_meta_q, comp_s_q;

  logic [N_CHNL-1:0]   dac_sel_q, dac_sel_d;
  logic                sh_rst_q, sh_rst_d;
  logic                sh_hold_q, sh_hold_d;
  logic [DAC_W-1:0]    dac_code_q, dac_code_d;
  logic                busy_q, busy_d;
  logic                res_vld_q, res_vld_d;
  logic [CW-1:0]       res_chn_q, res_chn_d;
  logic [DAC_W-1:0]    res_dat_q, res_dat_d;

  logic                pick_found;
  logic [CW-1:0]       pick_idx;
  logic [CW-1:0]       cand;
  logic [N_CHNL-1:0]   le_mask;
  logic                mask_above;

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      comp_meta_q <= 1'b0;
      comp_s_q    <= 1'b0;
    end else begin
      comp_meta_q <= comp_i;
      comp_s_q    <= comp_meta_q;
    end
  end

  // Round-robin search: first set mask bit above the pointer, with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    for (int unsigned i = 1; i <= N_CHNL; i++) begin
      cand = CW'((32'(ptr_q) + i) % N_CHNL);
      if (!pick_found && chn_mask[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Pass is complete when no enabled channel lies above the pointer
  always_comb begin
    le_mask    = (N_CHNL'(2) << ptr_q) - N_CHNL'(1);
    mask_above = |(chn_mask & ~le_mask);
  end

  // Next-state, SAR decision and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ptr_d   = ptr_q;
    kept_d  = kept_q;
    done_d  = done_q & scan_en;

    unique case (state_q)
      S_IDLE: if (scan_en && (|chn_mask) && !done_q) state_d = S_PICK;
      S_PICK: begin
        if (pick_found) begin
          ptr_d   = pick_idx;
          kept_d  = '0;
          cnt_d   = '0;
          state_d = S_RST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST: begin
        if (cnt_q == TW'(T_RST - 1)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else cnt_d = cnt_q + TW'(1);
      end
      S_GAP: begin
        if (cnt_q == TW'(T_GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_SMP;
        end else cnt_d = cnt_q + TW'(1);
      end
      S_SMP: begin
        if (cnt_q == TW'(T_SMP - 1)) begin
          cnt_d   = '0;
          bit_d   = BW'(DAC_W - 1);
          state_d = S_CONV;
        end else cnt_d = cnt_q + TW'(1);
      end
      S_CONV: begin
        if (cnt_q == TW'(T_BIT - 1)) begin
          cnt_d = '0;
          if (comp_s_q) kept_d = kept_q | (DAC_W'(1) << bit_q);
          if (bit_q == '0) state_d = S_DONE;
          else             bit_d   = bit_q - BW'(1);
        end else cnt_d = cnt_q + TW'(1);
      end
      S_DONE: begin
        if (!scan_en) begin
          state_d = S_IDLE;
        end else if (oneshot && !mask_above) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_PICK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dac_sel_d  = (state_d == S_SMP) ? (N_CHNL'(1) << ptr_d) : '0;
    sh_rst_d   = (state_d == S_RST);
    sh_hold_d  = (state_d != S_SMP);
    dac_code_d = (state_d == S_CONV) ? (kept_d | (DAC_W'(1) << bit_d)) : '0;
    busy_d     = (state_d != S_IDLE);
    res_vld_d  = (state_d == S_DONE);
    res_chn_d  = res_chn_q;
    res_dat_d  = res_dat_q;
    if (state_d == S_DONE) begin
      res_chn_d = ptr_d;
      res_dat_d = kept_d;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ptr_q      <= CW'(N_CHNL - 1);
      kept_q     <= '0;
      done_q     <= 1'b0;
      dac_sel_q  <= '0;
      sh_rst_q   <= 1'b0;
      sh_hold_q  <= 1'b1;
      dac_code_q <= '0;
      busy_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_chn_q  <= '0;
      res_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ptr_q      <= ptr_d;
      kept_q     <= kept_d;
      done_q     <= done_d;
      dac_sel_q  <= dac_sel_d;
      sh_rst_q   <= sh_rst_d;
      sh_hold_q  <= sh_hold_d;
      dac_code_q <= dac_code_d;
      busy_q     <= busy_d;
      res_vld_q  <= res_vld_d;
      res_chn_q  <= res_chn_d;
      res_dat_q  <= res_dat_d;
    end
  end

  assign dac_sel   = dac_sel_q;
  assign sh_rst    = sh_rst_q;
  assign sh_hold   = sh_hold_q;
  assign dac_code  = dac_code_q;
  assign busy      = busy_q;
  assign res_vld   = res_vld_q;
  assign res_chn   = res_chn_q;
  assign res_dat   = res_dat_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_sar_scan_ctl.sv
// Bench for sar_scan_ctl: analog comparator model, result scoreboard, overlap monitor.
module tb_sar_scan_ctl;

  localparam int N   = 14;
  localparam int DW  = 10;
  localparam int CW  = 4;
  localparam int PER = 53;

  logic          clk = 1'b0;
  logic          rstz = 1'b0;
  logic          scan_en = 1'b0;
  logic          oneshot = 1'b0;
  logic [N-1:0]  chn_mask = '0;
  logic          comp_i;
  logic [N-1:0]  dac_sel;
  logic          sh_rst, sh_hold, busy, res_vld, scan_done;
  logic [DW-1:0] dac_code, res_dat;
  logic [CW-1:0] res_chn;

  sar_scan_ctl #(.N_CHNL(N), .DAC_W(DW), .T_RST(2), .T_GAP(1), .T_SMP(8), .T_BIT(4)) dut (
    .clk(clk), .rstz(rstz), .scan_en(scan_en), .oneshot(oneshot), .chn_mask(chn_mask),
    .comp_i(comp_i), .dac_sel(dac_sel), .sh_rst(sh_rst), .sh_hold(sh_hold),
    .dac_code(dac_code), .busy(busy), .res_vld(res_vld), .res_chn(res_chn),
    .res_dat(res_dat), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Analog side: channel voltages in mV, S/H holds last selected channel, DAC is 2 mV/LSB
  int vin [N];
  int held_ch = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int j = 0; j < N; j++) if (dac_sel[j]) held_ch <= j;
  end
  assign comp_i = (vin[held_ch] > 2 * int'(dac_code));

  typedef struct { int chn; int dat; } exp_t;
  typedef struct { logic [N-1:0] mask; int n; int first_chn; int first_dat; } vec_t;

  exp_t sbq [$];
  exp_t e;
  vec_t tbl [4];
  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = N - 1;
  int fc, fd, cnt, got, bud;
  logic [N-1:0] rm;
  logic prev_sel = 1'b0, prev_rst = 1'b0, prev_hold = 1'b1;
  logic [3:0] viol;

  function automatic int exp_code(input int v);
    int r = 0;
    for (int c = 0; c < (1 << DW); c++) if (v > 2 * c) r = c;
    return r;
  endfunction

  function automatic int next_ptr(input int p, input logic [N-1:0] m);
    for (int i = 1; i <= N; i++) begin
      int c = (p + i) % N;
      if (m[c]) return c;
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int ch);
    exp_t x;
    x.chn = ch;
    x.dat = exp_code(vin[ch]);
    sbq.push_back(x);
  endtask

  task automatic do_reset();
    rstz = 1'b0; scan_en = 1'b0; oneshot = 1'b0; chn_mask = '0;
    repeat (3) @(negedge clk);
    rstz = 1'b1;
    m_ptr = N - 1;
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    while (busy && b > 0) begin @(negedge clk); b--; end
    if (busy) chk("timeout_idle", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  // Continuous scan of n conversions on mask; optional scan_en drop on the last DONE
  task automatic run_scan(input logic [N-1:0] mask, input int n, input bit stop,
                          output int first_chn, output int first_dat);
    int g = 0, b = n * PER + 200, last = -1;
    first_chn = -1; first_dat = -1;
    chn_mask = mask;
    for (int k = 0; k < n; k++) begin
      m_ptr = next_ptr(m_ptr, mask);
      push_exp(m_ptr);
    end
    scan_en = 1'b1;
    while (g < n && b > 0) begin
      @(negedge clk); b--;
      if (res_vld) begin
        if (g == 0) begin first_chn = int'(res_chn); first_dat = int'(res_dat); end
        if (last >= 0) chk("period", cyc - last, PER);
        last = cyc;
        g++;
        if (g == n && stop) scan_en = 1'b0;
      end
    end
    if (g < n) chk("timeout_results", g, n);
  endtask

  initial begin
    for (int i = 0; i < N; i++) vin[i] = i * 140 + 33;
    vin[0] = 0; vin[1] = 1000; vin[2] = 700; vin[5] = 2046;

    tbl[0] = '{14'h0004, 4, 2, 349};
    tbl[1] = '{14'h0023, 6, 0, 0};
    tbl[2] = '{14'h2001, 4, 0, 0};
    tbl[3] = '{14'h2000, 2, 13, 926};

    // Monitor: scoreboard pop on res_vld, non-overlap and one-hot rules every cycle
    fork
      forever begin
        @(negedge clk);
        if (rstz) begin
          viol[0] = (|dac_sel) & sh_rst;
          viol[1] = (prev_sel & sh_rst) | ((|dac_sel) & prev_rst);
          viol[2] = (~sh_hold & sh_rst) | (~sh_hold & prev_rst) | (~prev_hold & sh_rst);
          viol[3] = ~$onehot0(dac_sel);
          chk("overlap", 32'(viol), 0);
          if (res_vld) begin
            if (sbq.size() == 0) chk("unexpected_res_vld", 1, 0);
            else begin
              e = sbq.pop_front();
              chk("res_chn", 32'(res_chn), e.chn);
              chk("res_dat", 32'(res_dat), e.dat);
            end
          end
        end
        prev_sel = |dac_sel; prev_rst = sh_rst; prev_hold = sh_hold;
      end
    join_none

    // Reset values, during and after reset
    repeat (2) @(negedge clk);
    chk("rst_dac_sel", 32'(dac_sel), 0);
    chk("rst_sh_rst", 32'(sh_rst), 0);
    chk("rst_sh_hold", 32'(sh_hold), 1);
    chk("rst_dac_code", 32'(dac_code), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_vld", 32'(res_vld), 0);
    chk("rst_res_chn", 32'(res_chn), 0);
    chk("rst_res_dat", 32'(res_dat), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    rstz = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sh_hold", 32'(sh_hold), 1);

    // Table-driven continuous scans
    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_scan(tbl[i].mask, tbl[i].n, 1'b1, fc, fd);
      chk("tbl_first_chn", fc, tbl[i].first_chn);
      chk("tbl_first_dat", fd, tbl[i].first_dat);
      wait_idle(100);
      chk("tbl_sb_drained", sbq.size(), 0);
    end

    // One-shot pass, quiet until scan_en toggles, restart at lowest channel
    do_reset();
    oneshot = 1'b1;
    run_scan(14'h0300, 2, 1'b0, fc, fd);
    chk("os_first_chn", fc, 8);
    wait_idle(100);
    chk("os_scan_done", 32'(scan_done), 1);
    chk("os_busy", 32'(busy), 0);
    cnt = 0;
    repeat (150) begin @(negedge clk); if (busy || res_vld) cnt++; end
    chk("os_quiet", cnt, 0);
    scan_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("os_done_clear", 32'(scan_done), 0);
    run_scan(14'h0300, 2, 1'b0, fc, fd);
    chk("os_restart_chn", fc, 8);
    wait_idle(100);
    chk("os_scan_done2", 32'(scan_done), 1);
    chk("os_sb_drained", sbq.size(), 0);

    // scan_en dropped during bit 5 of CONV: channel still completes
    do_reset();
    chn_mask = 14'h0004;
    m_ptr = next_ptr(m_ptr, chn_mask);
    push_exp(m_ptr);
    scan_en = 1'b1;
    bud = 200;
    while (!(busy && dac_code[5:0] == 6'h20) && bud > 0) begin @(negedge clk); bud--; end
    chk("drop_reached_bit5", 32'(bud > 0), 1);
    scan_en = 1'b0;
    cnt = 0;
    repeat (150) begin @(negedge clk); if (res_vld) cnt++; end
    chk("drop_res_cnt", cnt, 1);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_sb_drained", sbq.size(), 0);

    // Reset asserted during sampling
    do_reset();
    chn_mask = 14'h0004;
    scan_en = 1'b1;
    bud = 100;
    while (sh_hold && bud > 0) begin @(negedge clk); bud--; end
    chk("smp_reached", 32'(sh_hold), 0);
    @(negedge clk);
    rstz = 1'b0;
    #1;
    chk("smp_rst_dac_sel", 32'(dac_sel), 0);
    chk("smp_rst_sh_hold", 32'(sh_hold), 1);
    chk("smp_rst_dac_code", 32'(dac_code), 0);
    chk("smp_rst_busy", 32'(busy), 0);
    chk("smp_rst_res_vld", 32'(res_vld), 0);
    scan_en = 1'b0;
    @(negedge clk);
    rstz = 1'b1;
    cnt = 0;
    repeat (100) begin @(negedge clk); if (busy || res_vld) cnt++; end
    chk("smp_rst_quiet", cnt, 0);

    // Empty mask stays idle; late mask enable and mid-CONV mask change with wrap
    do_reset();
    chn_mask = '0;
    scan_en = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || (|dac_sel) || sh_rst || !sh_hold || (|dac_code) || res_vld) cnt++;
    end
    chk("nomask_quiet", cnt, 0);
    run_scan(14'h2000, 1, 1'b0, fc, fd);
    chk("late_mask_chn", fc, 13);
    m_ptr = next_ptr(m_ptr, 14'h2000);
    push_exp(m_ptr);
    bud = 200;
    while (dac_code == '0 && bud > 0) begin @(negedge clk); bud--; end
    chk("mask_chg_in_conv", 32'(dac_code != '0), 1);
    chn_mask = 14'h0001;
    m_ptr = next_ptr(m_ptr, 14'h0001);
    push_exp(m_ptr);
    got = 0; fc = -1; bud = 3 * PER;
    while (got < 2 && bud > 0) begin
      @(negedge clk); bud--;
      if (res_vld) begin
        got++;
        if (got == 2) begin fc = int'(res_chn); scan_en = 1'b0; end
      end
    end
    chk("wrap_res_cnt", got, 2);
    chk("wrap_chn", fc, 0);
    wait_idle(100);
    chk("wrap_sb_drained", sbq.size(), 0);

    // 100 conversions over random masks, continuous, mask changed on DONE
    do_reset();
    for (int b = 0; b < 10; b++) begin
      rm = N'($urandom_range(16383, 1));
      run_scan(rm, 10, (b == 9), fc, fd);
    end
    wait_idle(100);
    chk("rand_sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
